rename_dispatch: RTL

Rename-and-dispatch stage directly upstream of the ALU reservation station. It accepts one decoded instruction per cycle and renames its destination to a free 5-bit virtual register (vreg). It resolves each source to either a value or a vreg tag by snooping the three writeback buses, then presents a registered issue packet on the station's input port. It also owns the architectural register file and the rename map.

---
 rtl/rename_pkg.sv | 23 ++
 rtl/vreg_free_list.sv | 61 ++++++
 rtl/rename_dispatch.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// rename_pkg: shared widths, the vreg tag type and the issue-packet layout
// used by the rename/dispatch stage and its free list.
package rename_pkg;

   localparam int VREG_W   = 5;
   localparam int NUM_VREG = 32;
   localparam int OPC_W    = 5;
   localparam int DATA_W   = 32;

   typedef logic [VREG_W-1:0] vreg_t;

   // Registered packet presented to the reservation station. A dependent
   // operand carries its tag in bits [VREG_W-1:0] with zeros above.
   typedef struct packed {
      logic [OPC_W-1:0]  op_type;
      vreg_t             vdest_id;
      logic              op1_dep;
      logic [DATA_W-1:0] op1;
      logic              op2_dep;
      logic [DATA_W-1:0] op2;
   } issue_pkt_t;

endpackage

// File: rtl/vreg_free_list.sv
// vreg_free_list: free bitmap over the vreg tags with a lowest-index
// allocator.
//   clk, rst_n          clock, asynchronous active-low reset (all tags free)
//   alloc_en            consume alloc_id this cycle
//   alloc_id, alloc_ok  lowest free tag and whether any tag is free
//   freeN_en, freeN_id  return a tag (three writeback ports)
// A tag returned this cycle only shows up in alloc_id from the next cycle,
// because the encoder looks at the registered bitmap.
module vreg_free_list
   import rename_pkg::*;
#(
   parameter int NUM_TAGS = NUM_VREG
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  alloc_en,
   output vreg_t alloc_id,
   output logic  alloc_ok,
   input  logic  free1_en,
   input  vreg_t free1_id,
   input  logic  free2_en,
   input  vreg_t free2_id,
   input  logic  free3_en,
   input  vreg_t free3_id
);

   logic [NUM_TAGS-1:0] free_q;
   logic [NUM_TAGS-1:0] free_d;

   // Scan from the top so the last hit, the lowest index, wins.
   always_comb begin
      alloc_ok = 1'b0;
      alloc_id = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (free_q[i]) begin
            alloc_ok = 1'b1;
            alloc_id = VREG_W'(i);
         end
      end
   end

   always_comb begin
      free_d = free_q;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (alloc_en && (alloc_id == VREG_W'(i)))
            free_d[i] = 1'b0;
         if ((free1_en && (free1_id == VREG_W'(i))) ||
             (free2_en && (free2_id == VREG_W'(i))) ||
             (free3_en && (free3_id == VREG_W'(i))))
            free_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         free_q <= '1;
      else
         free_q <= free_d;
   end

endmodule

// File: rtl/rename_dispatch.sv
// rename_dispatch: renames one decoded instruction per cycle, resolves its
// sources against the map, register file and writeback buses, and presents
// a registered issue packet to the ALU reservation station. Owns the
// architectural register file and the rename map.
//   clk, rst_n                    clock, asynchronous active-low reset
//   dec_*                         decoded instruction, dec_ready handshake
//   rs_full                       station cannot take a packet next cycle
//   wbN_en/_vregid/_val           three writeback buses
//   in_en, op_type, vdest_id,
//   opN_dependent, opN            registered issue packet
//   dbg_idx, dbg_val              combinational register file read
// Build option: RENAME_WB_BYPASS_EN forwards same-cycle writebacks into
// source lookup; without it a source hitting a writeback stalls one cycle.
module rename_dispatch #(
   parameter int NUM_VREG = rename_pkg::NUM_VREG,
   parameter int XLEN     = rename_pkg::DATA_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dec_valid,
   output logic            dec_ready,
   input  logic [4:0]      dec_op_type,
   input  logic            dec_rd_en,
   input  logic [4:0]      dec_rd,
   input  logic [4:0]      dec_rs1,
   input  logic [4:0]      dec_rs2,
   input  logic            dec_use_imm,
   input  logic [XLEN-1:0] dec_imm,
   input  logic            rs_full,
   input  logic            wb1_en,
   input  logic [4:0]      wb1_vregid,
   input  logic [XLEN-1:0] wb1_val,
   input  logic            wb2_en,
   input  logic [4:0]      wb2_vregid,
   input  logic [XLEN-1:0] wb2_val,
   input  logic            wb3_en,
   input  logic [4:0]      wb3_vregid,
   input  logic [XLEN-1:0] wb3_val,
   output logic            in_en,
   output logic [4:0]      op_type,
   output logic [4:0]      vdest_id,
   output logic            op1_dependent,
   output logic            op2_dependent,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   input  logic [4:0]      dbg_idx,
   output logic [XLEN-1:0] dbg_val
);

   import rename_pkg::*;

   typedef struct packed {
      logic            dep;
      logic            stall;
      logic [XLEN-1:0] val;
   } src_res_t;

   logic [XLEN-1:0] regfile [32];
   logic            map_busy [32];
   vreg_t           map_tag [32];

   vreg_t      fl_alloc_id;
   logic       fl_alloc_ok;
   logic       alloc_ok;
   logic       bypass_stall;
   logic       fire;
   logic       alloc_do;
   src_res_t   src1;
   src_res_t   src2;
   issue_pkt_t pkt_p0;
   issue_pkt_t pkt_p1;
   logic       vld_p1;

   function automatic src_res_t resolve(input logic [4:0]      idx,
                                        input logic            busy,
                                        input vreg_t           tag,
                                        input logic [XLEN-1:0] rf_val);
      src_res_t r;
      logic     h1, h2, h3;
      r  = '0;
      h1 = wb1_en && (wb1_vregid == tag);
      h2 = wb2_en && (wb2_vregid == tag);
      h3 = wb3_en && (wb3_vregid == tag);
      if (idx == 5'd0) begin
         r = '0;
      end else if (!busy) begin
         r.val = rf_val;
      end else begin
`ifdef RENAME_WB_BYPASS_EN
         if (h1)      r.val = wb1_val;
         else if (h2) r.val = wb2_val;
         else if (h3) r.val = wb3_val;
         else begin
            r.dep = 1'b1;
            r.val = XLEN'(tag);
         end
`else
         // The regfile only holds the value next cycle; retry then.
         r.dep   = 1'b1;
         r.val   = XLEN'(tag);
         r.stall = h1 | h2 | h3;
`endif
      end
      return r;
   endfunction

   vreg_free_list #(
      .NUM_TAGS (NUM_VREG)
   ) u_free_list (
      .clk      (clk),
      .rst_n    (rst_n),
      .alloc_en (alloc_do),
      .alloc_id (fl_alloc_id),
      .alloc_ok (fl_alloc_ok),
      .free1_en (wb1_en),
      .free1_id (wb1_vregid),
      .free2_en (wb2_en),
      .free2_id (wb2_vregid),
      .free3_en (wb3_en),
      .free3_id (wb3_vregid)
   );

   // ---- stage p0: lookup against the pre-update map, accept, allocate ----
   always_comb begin
      src1 = resolve(dec_rs1, map_busy[dec_rs1], map_tag[dec_rs1], regfile[dec_rs1]);
      src2 = '0;
      if (!dec_use_imm)
         src2 = resolve(dec_rs2, map_busy[dec_rs2], map_tag[dec_rs2], regfile[dec_rs2]);
   end

   assign bypass_stall = src1.stall | src2.stall;
   assign alloc_ok     = !dec_rd_en || (dec_rd == 5'd0) || fl_alloc_ok;
   assign dec_ready    = rst_n && !rs_full && alloc_ok && !bypass_stall;
   assign fire         = dec_valid && dec_ready;
   assign alloc_do     = fire && dec_rd_en && (dec_rd != 5'd0);

   always_comb begin
      pkt_p0.op_type  = dec_op_type;
      pkt_p0.vdest_id = alloc_do ? fl_alloc_id : '0;
      pkt_p0.op1_dep  = src1.dep;
      pkt_p0.op1      = src1.val;
      pkt_p0.op2_dep  = dec_use_imm ? 1'b0 : src2.dep;
      pkt_p0.op2      = dec_use_imm ? dec_imm : src2.val;
   end

   // x0 is hardwired: never busy, never written.
   assign regfile[0]  = '0;
   assign map_busy[0] = 1'b0;
   assign map_tag[0]  = '0;

   for (genvar g = 1; g < 32; g++) begin : g_arch
      logic [XLEN-1:0] rf_q;
      logic            busy_q;
      vreg_t           tag_q;
      logic            hit1, hit2, hit3, realloc;

      assign hit1    = busy_q && wb1_en && (wb1_vregid == tag_q);
      assign hit2    = busy_q && wb2_en && (wb2_vregid == tag_q);
      assign hit3    = busy_q && wb3_en && (wb3_vregid == tag_q);
      assign realloc = alloc_do && (dec_rd == VREG_W'(g));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rf_q   <= '0;
            busy_q <= 1'b0;
            tag_q  <= '0;
         end else begin
            if (hit1)      rf_q <= wb1_val;
            else if (hit2) rf_q <= wb2_val;
            else if (hit3) rf_q <= wb3_val;
            // A same-cycle re-rename keeps the register busy under the new tag.
            if (realloc) begin
               busy_q <= 1'b1;
               tag_q  <= fl_alloc_id;
            end else if (hit1 || hit2 || hit3) begin
               busy_q <= 1'b0;
            end
         end
      end

      assign regfile[g]  = rf_q;
      assign map_busy[g] = busy_q;
      assign map_tag[g]  = tag_q;
   end

   // ---- stage p1: registered issue packet ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         pkt_p1 <= '0;
      end else begin
         vld_p1 <= fire;
         if (fire)
            pkt_p1 <= pkt_p0;
      end
   end

   assign in_en         = vld_p1;
   assign op_type       = pkt_p1.op_type;
   assign vdest_id      = pkt_p1.vdest_id;
   assign op1_dependent = pkt_p1.op1_dep;
   assign op1           = pkt_p1.op1;
   assign op2_dependent = pkt_p1.op2_dep;
   assign op2           = pkt_p1.op2;

   assign dbg_val = regfile[dbg_idx];

endmodule
